neo_rtc_seq: RTL and testbench
==============================

// Module: neo_rtc_seq
// PURPOSE
// Hardware serial sequencer for the uPD4990 RTC on the IO board. Replaces slow
// 68k bit-banging of DIN/CLK/STROBE: one START shifts an optional 48-bit data
// frame plus a 4-bit command, pulses STROBE, and captures DOUT into RD_DATA.
// When idle, the RTC pins are muxed to the 68k bit-bang control bits.
// PARAMETERS
// DIV      4  sys clocks per CLK phase (low and high); legal 1..255
// STB_LEN  4  sys clocks STROBE held high after the last bit; legal 1..255
// PORTS
// CLK         in   1   system clock, all state on rising edge
// nRESET      in   1   reset, synchronous, active-low
// START       in   1   1-cycle request; sampled only while BUSY=0
// CMD         in   4   uPD4990 command, shifted LSB first
// SHIFT_DATA  in   1   1: shift WR_DATA before CMD; 0: command only
// WR_DATA     in   48  data frame, shifted LSB first
// BB_EN       in   1   1: idle pins follow BB_CTRL (68k bit-bang mode)
// BB_CTRL     in   3   {STROBE,CLK,DIN} from 68k RTC control register
// RTC_DOUT    in   1   serial data from RTC (already synchronised)
// RTC_DIN     out  1   serial data to RTC
// RTC_CLK     out  1   shift clock to RTC
// RTC_STROBE  out  1   command strobe to RTC
// BUSY        out  1   transaction in progress
// DONE        out  1   1-cycle pulse at transaction end
// RD_DATA     out  48  last frame captured from DOUT
// BEHAVIOUR
// - Reset (nRESET=0 at edge): state IDLE, RTC_DIN/CLK/STROBE=0, BUSY=0,
//   DONE=0, RD_DATA=0, all counters 0. Reset mid-transaction aborts at once;
//   no partial strobe, RD_DATA cleared.
// - FSM: IDLE -> LOW -> HIGH -> (LOW | STB) ; STB -> IDLE.
// - IDLE: BUSY=0. Pins = BB_EN ? BB_CTRL : 3'b000 (registered, 1 cycle lag).
//   START=1 at edge k: latch CMD/WR_DATA/SHIFT_DATA into a 52-bit shift reg
//   ({CMD,WR_DATA} or CMD alone), nbits=52 or 4, bit counter=0; at k+1
//   BUSY=1, state LOW, DIN=bit0, CLK=0, STROBE=0. BB_CTRL ignored until IDLE.
// - LOW: CLK=0, DIN=current bit, DIV cycles. On last LOW cycle, if bit index
//   < 48 and SHIFT_DATA: RD_DATA <= {RTC_DOUT, RD_DATA[47:1]} (sample before
//   rising CLK). Then HIGH.
// - HIGH: CLK=1, DIN held, DIV cycles. Then if bit index == nbits-1 -> STB,
//   else index+1, shift reg >>1, -> LOW.
// - STB: CLK=0, DIN=0, STROBE=1 for STB_LEN cycles, then IDLE; DONE=1 in the
//   first IDLE cycle (same cycle BUSY=0), 0 otherwise.
// - Length BUSY=1: nbits*2*DIV + STB_LEN cycles (DIV=4,STB_LEN=4: cmd-only
//   36, with data 420).
// - START while BUSY: ignored, no queueing. START in the DONE cycle accepted.
// - SHIFT_DATA=0: RD_DATA unchanged by the transaction.
// - RD_DATA stable while BUSY=0; after a data frame RD_DATA[0] = first DOUT bit.
// - Phase counter width 8 bits; bit counter 6 bits, never wraps (max 51).
// - Outputs are registered; no combinational path input->RTC pins.
// TESTING
// 1 Reset: nRESET=0 two cycles mid data frame -> pins/BUSY/DONE/RD_DATA all 0
//   next cycle, FSM IDLE, following START runs full 420-cycle frame.
// 2 Cmd-only: CMD=4'b0011, SHIFT_DATA=0, DIV=4, STB_LEN=4 -> DIN 1,1,0,0 on 4
//   CLK rises, STROBE high 4 cycles, BUSY 36 cycles, one DONE pulse, RD_DATA kept.
// 3 Data frame: WR_DATA=48'h0123_4567_89AB, CMD=4'h2, RTC model DOUT
//   returning 48'hA5A5_5A5A_F00F -> 52 CLK rises, DIN order matches LSB-first
//   {CMD,WR_DATA}, RD_DATA=48'hA5A5_5A5A_F00F at DONE.
// 4 Bit-bang: BB_EN=1, BB_CTRL=3'b101 idle -> STROBE=1,CLK=0,DIN=1 next cycle;
//   START issued -> sequencer owns pins, BB_CTRL=3'b111 changes ignored until
//   BUSY=0, then pins return to BB_CTRL.
// 5 Collision: START pulses at BUSY-rise+3 and +20 -> ignored, single DONE;
//   START in DONE cycle -> BUSY=1 next cycle, back-to-back frame.
// 6 DIV=1, STB_LEN=1: cmd-only -> BUSY exactly 9 cycles, CLK toggles every cycle.

Source files
------------

// File: rtl/neo_rtc_seq.sv
// Serial sequencer for the uPD4990 RTC: shifts {CMD,WR_DATA} LSB first, strobes, captures DOUT.
// Latency: BUSY the cycle after START, held nbits*2*DIV+STB_LEN cycles, then a 1-cycle DONE.
// Backpressure: none; START is only sampled while idle and is otherwise dropped, never queued.
module neo_rtc_seq #(
    parameter int DIV     = 4,
    parameter int STB_LEN = 4
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        START,
    input  logic [3:0]  CMD,
    input  logic        SHIFT_DATA,
    input  logic [47:0] WR_DATA,
    input  logic        BB_EN,
    input  logic [2:0]  BB_CTRL,
    input  logic        RTC_DOUT,
    output logic        RTC_DIN,
    output logic        RTC_CLK,
    output logic        RTC_STROBE,
    output logic        BUSY,
    output logic        DONE,
    output logic [47:0] RD_DATA
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_STB  = 2'd3;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0] STB_LAST = 8'(STB_LEN - 1);

    logic [1:0]  state;
    logic [7:0]  phase_cnt;
    logic [5:0]  bit_idx;
    logic [51:0] shreg;
    logic        shift_r;
    logic [5:0]  last_idx;

    assign last_idx = shift_r ? 6'd51 : 6'd3;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state      <= ST_IDLE;
            phase_cnt  <= 8'd0;
            bit_idx    <= 6'd0;
            shreg      <= 52'd0;
            shift_r    <= 1'b0;
            RTC_DIN    <= 1'b0;
            RTC_CLK    <= 1'b0;
            RTC_STROBE <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            RD_DATA    <= 48'd0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        shreg      <= SHIFT_DATA ? {CMD, WR_DATA} : {48'd0, CMD};
                        shift_r    <= SHIFT_DATA;
                        bit_idx    <= 6'd0;
                        phase_cnt  <= 8'd0;
                        state      <= ST_LOW;
                        BUSY       <= 1'b1;
                        RTC_DIN    <= SHIFT_DATA ? WR_DATA[0] : CMD[0];
                        RTC_CLK    <= 1'b0;
                        RTC_STROBE <= 1'b0;
                    end else begin
                        // Bit-bang passthrough: {STROBE,CLK,DIN}
                        RTC_STROBE <= BB_EN & BB_CTRL[2];
                        RTC_CLK    <= BB_EN & BB_CTRL[1];
                        RTC_DIN    <= BB_EN & BB_CTRL[0];
                    end
                end
                ST_LOW: begin
                    if (phase_cnt == DIV_LAST) begin
                        // Sample DOUT just before the rising shift clock
                        if (shift_r && bit_idx < 6'd48)
                            RD_DATA <= {RTC_DOUT, RD_DATA[47:1]};
                        phase_cnt <= 8'd0;
                        RTC_CLK   <= 1'b1;
                        state     <= ST_HIGH;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (phase_cnt == DIV_LAST) begin
                        phase_cnt <= 8'd0;
                        RTC_CLK   <= 1'b0;
                        if (bit_idx == last_idx) begin
                            RTC_DIN    <= 1'b0;
                            RTC_STROBE <= 1'b1;
                            state      <= ST_STB;
                        end else begin
                            bit_idx <= bit_idx + 6'd1;
                            shreg   <= {1'b0, shreg[51:1]};
                            RTC_DIN <= shreg[1];
                            state   <= ST_LOW;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                default: begin
                    if (phase_cnt == STB_LAST) begin
                        phase_cnt  <= 8'd0;
                        RTC_STROBE <= 1'b0;
                        BUSY       <= 1'b0;
                        DONE       <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neo_rtc_seq.sv
// Directed bench for neo_rtc_seq: DIV=4/STB_LEN=4 instance plus a DIV=1/STB_LEN=1 instance.
module tb_neo_rtc_seq;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [3:0]  cmd;
    logic        shift_data;
    logic [47:0] wr_data;
    logic        bb_en;
    logic [2:0]  bb_ctrl;
    logic        rtc_dout;

    logic        din0, clk0, stb0, busy0, done0;
    logic [47:0] rd0;
    logic        din1, clk1, stb1, busy1, done1;
    logic [47:0] rd1;

    int checks = 0;
    int errors = 0;

    int          rise_cnt = 0;
    int          base = 0;
    int          rel;
    logic [63:0] din_cap = 64'd0;
    logic [47:0] dout_pat = 48'd0;

    always #5 clk = ~clk;

    neo_rtc_seq #(.DIV(4), .STB_LEN(4)) u0 (
        .CLK(clk), .nRESET(nreset), .START(start), .CMD(cmd), .SHIFT_DATA(shift_data),
        .WR_DATA(wr_data), .BB_EN(bb_en), .BB_CTRL(bb_ctrl), .RTC_DOUT(rtc_dout),
        .RTC_DIN(din0), .RTC_CLK(clk0), .RTC_STROBE(stb0), .BUSY(busy0), .DONE(done0),
        .RD_DATA(rd0)
    );

    neo_rtc_seq #(.DIV(1), .STB_LEN(1)) u1 (
        .CLK(clk), .nRESET(nreset), .START(start), .CMD(cmd), .SHIFT_DATA(shift_data),
        .WR_DATA(wr_data), .BB_EN(bb_en), .BB_CTRL(bb_ctrl), .RTC_DOUT(rtc_dout),
        .RTC_DIN(din1), .RTC_CLK(clk1), .RTC_STROBE(stb1), .BUSY(busy1), .DONE(done1),
        .RD_DATA(rd1)
    );

    // RTC model: logs DIN at each rising shift clock and presents the next DOUT bit
    always @(posedge clk0) begin
        if (rise_cnt - base >= 0 && rise_cnt - base < 64)
            din_cap[6'(rise_cnt - base)] = din0;
        rise_cnt = rise_cnt + 1;
    end

    always_comb begin
        rel = rise_cnt - base;
        rtc_dout = (rel >= 0 && rel < 48) ? dout_pat[6'(rel)] : 1'b0;
    end

    task automatic run_txn(input logic [3:0] c, input logic sd, input int pa, input int pb,
                           output int busy_n, output int done_n, output int stb_n);
        int cnt;
        cmd = c;
        shift_data = sd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        done_n = 0;
        stb_n = 0;
        while (busy0 && cnt < 2000) begin
            cnt++;
            if (done0) done_n++;
            if (stb0) stb_n++;
            start = (cnt == pa || cnt == pb);
            @(negedge clk);
        end
        start = 1'b0;
        busy_n = cnt;
        if (done0) done_n++;
    endtask

    task automatic test_reset();
        int bn, dn, sn;
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        checks++;
        if ({din0, clk0, stb0, busy0, done0} !== 5'b0 || rd0 !== 48'd0) begin
            errors++;
            $display("FAIL reset_state: pins/busy/done=%b rd=%h, required 0/0", {din0, clk0, stb0, busy0, done0}, rd0);
        end
        dout_pat = 48'hFFFF_FFFF_FFFF;
        base = rise_cnt;
        wr_data = 48'h0123_4567_89AB;
        cmd = 4'h2;
        shift_data = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        nreset = 1'b0;
        @(negedge clk);
        checks++;
        if ({din0, clk0, stb0, busy0, done0} !== 5'b0 || rd0 !== 48'd0) begin
            errors++;
            $display("FAIL reset_abort: pins/busy/done=%b rd=%h, required 0/0", {din0, clk0, stb0, busy0, done0}, rd0);
        end
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || stb0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b strobe=%b, required 0 0", busy0, stb0);
        end
        dout_pat = 48'hA5A5_5A5A_F00F;
        base = rise_cnt;
        run_txn(4'h2, 1'b1, -1, -1, bn, dn, sn);
        checks++;
        if (bn !== 420) begin
            errors++;
            $display("FAIL reset_rerun_busy: busy cycles %0d, required 420", bn);
        end
        checks++;
        if (rd0 !== 48'hA5A5_5A5A_F00F) begin
            errors++;
            $display("FAIL reset_rerun_rd: rd=%h, required a5a55a5af00f", rd0);
        end
    endtask

    task automatic test_data_frame();
        int bn, dn, sn;
        int r0;
        logic [51:0] exp_din;
        exp_din = {4'h2, 48'h0123_4567_89AB};
        wr_data = 48'h0123_4567_89AB;
        dout_pat = 48'hA5A5_5A5A_F00F;
        base = rise_cnt;
        r0 = rise_cnt;
        run_txn(4'h2, 1'b1, -1, -1, bn, dn, sn);
        checks++;
        if (rise_cnt - r0 !== 52) begin
            errors++;
            $display("FAIL data_rises: %0d clk rises, required 52", rise_cnt - r0);
        end
        checks++;
        if (din_cap[51:0] !== exp_din) begin
            errors++;
            $display("FAIL data_din_order: din=%h, required %h", din_cap[51:0], exp_din);
        end
        checks++;
        if (rd0 !== 48'hA5A5_5A5A_F00F || dn !== 1) begin
            errors++;
            $display("FAIL data_rd: rd=%h done=%0d, required a5a55a5af00f 1", rd0, dn);
        end
        checks++;
        if (sn !== 4) begin
            errors++;
            $display("FAIL data_strobe: strobe cycles %0d, required 4", sn);
        end
    endtask

    task automatic test_cmd_only();
        int bn, dn, sn;
        int r0;
        wr_data = 48'hFFFF_0000_FFFF;
        dout_pat = 48'd0;
        base = rise_cnt;
        r0 = rise_cnt;
        run_txn(4'b0011, 1'b0, -1, -1, bn, dn, sn);
        checks++;
        if (rise_cnt - r0 !== 4 || din_cap[3:0] !== 4'b0011) begin
            errors++;
            $display("FAIL cmd_din: rises=%0d din=%b, required 4 0011", rise_cnt - r0, din_cap[3:0]);
        end
        checks++;
        if (bn !== 36) begin
            errors++;
            $display("FAIL cmd_busy: busy cycles %0d, required 36", bn);
        end
        checks++;
        if (sn !== 4 || dn !== 1) begin
            errors++;
            $display("FAIL cmd_strobe_done: strobe=%0d done=%0d, required 4 1", sn, dn);
        end
        checks++;
        if (rd0 !== 48'hA5A5_5A5A_F00F) begin
            errors++;
            $display("FAIL cmd_rd_kept: rd=%h, required a5a55a5af00f", rd0);
        end
    endtask

    task automatic test_bitbang();
        int cnt;
        int sn;
        bb_en = 1'b1;
        bb_ctrl = 3'b101;
        @(negedge clk);
        checks++;
        if ({stb0, clk0, din0} !== 3'b101) begin
            errors++;
            $display("FAIL bb_idle: pins=%b, required 101", {stb0, clk0, din0});
        end
        cmd = 4'b1000;
        shift_data = 1'b0;
        bb_ctrl = 3'b111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({stb0, clk0, din0} !== 3'b000 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL bb_owned: pins=%b busy=%b, required 000 1", {stb0, clk0, din0}, busy0);
        end
        cnt = 0;
        sn = 0;
        while (busy0 && cnt < 2000) begin
            cnt++;
            if (stb0) sn++;
            @(negedge clk);
        end
        checks++;
        if (sn !== 4 || cnt !== 36) begin
            errors++;
            $display("FAIL bb_ignored: strobe=%0d busy=%0d, required 4 36", sn, cnt);
        end
        @(negedge clk);
        checks++;
        if ({stb0, clk0, din0} !== 3'b111) begin
            errors++;
            $display("FAIL bb_return: pins=%b, required 111", {stb0, clk0, din0});
        end
        bb_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({stb0, clk0, din0} !== 3'b000) begin
            errors++;
            $display("FAIL bb_off: pins=%b, required 000", {stb0, clk0, din0});
        end
    endtask

    task automatic test_back_to_back();
        int bn, dn, sn;
        run_txn(4'b0011, 1'b0, 3, 20, bn, dn, sn);
        checks++;
        if (bn !== 36 || dn !== 1) begin
            errors++;
            $display("FAIL collide: busy=%0d done=%0d, required 36 1", bn, dn);
        end
        run_txn(4'b0011, 1'b0, -1, -1, bn, dn, sn);
        checks++;
        if (bn !== 36 || dn !== 1) begin
            errors++;
            $display("FAIL back_to_back: busy=%0d done=%0d, required 36 1", bn, dn);
        end
    endtask

    task automatic test_div1();
        int cnt;
        int g;
        logic [8:0] clk_seq;
        clk_seq = 9'd0;
        cmd = 4'b0011;
        shift_data = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy1 && cnt < 100) begin
            if (cnt < 9) clk_seq[cnt] = clk1;
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 9 || done1 !== 1'b1) begin
            errors++;
            $display("FAIL div1_busy: busy=%0d done=%b, required 9 1", cnt, done1);
        end
        checks++;
        if (clk_seq !== 9'h0AA) begin
            errors++;
            $display("FAIL div1_clk: clk seq=%b, required 010101010", clk_seq);
        end
        g = 0;
        while (busy0 && g < 100) begin
            g++;
            @(negedge clk);
        end
    endtask

    initial begin
        nreset = 1'b0;
        start = 1'b0;
        cmd = 4'd0;
        shift_data = 1'b0;
        wr_data = 48'd0;
        bb_en = 1'b0;
        bb_ctrl = 3'b000;
        @(negedge clk);
        test_reset();
        test_data_frame();
        test_cmd_only();
        test_bitbang();
        test_back_to_back();
        test_div1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
